seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Display controller for the 8-digit multiplexed 7-segment board. Holds a host-written
//   double-buffered frame (BCD value + decimal point per digit), scans digits left to right
//   with a programmable slot time and an anti-ghosting blank interval, and drives digit/seg_data.
//   Host writes a shadow buffer; a commit request swaps it into the displayed buffer at the next
//   frame boundary, so the display never tears.
// PARAMETERS
//   CLK_DIV    500  clk cycles per digit slot (>= BLANK_CYC+1)
//   BLANK_CYC  16   cycles at the start of each slot with all outputs off (0 = no blanking)
// PORTS
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   en          in   1  1 = scan; 0 = outputs forced 0, counters held at 0
//   wr_en       in   1  write shadow[wr_addr] this cycle
//   wr_addr     in   3  digit index, 0 = leftmost
//   wr_bcd      in   5  value 0..9 shown; 10..31 = blank digit
//   wr_dp       in   1  decimal point for that digit
//   commit      in   1  request shadow->active swap at next frame boundary
//   commit_ack  out  1  1-cycle pulse: swap performed
//   frame_start out  1  1-cycle pulse aligned with first output cycle of slot 0
//   digit       out  8  one-hot digit enable, slot k = 8'h80 >> k
//   seg_data    out  8  {a,b,c,d,e,f,g,dp}, active-high
// BEHAVIOUR
//   Reset: shadow/active entries = {bcd 5'h1F, dp 0}; cnt=0, slot=0, pending=0;
//     digit=0, seg_data=0, commit_ack=0, frame_start=0.
//   Counters: cnt 0..CLK_DIV-1 increments every cycle while en=1; at CLK_DIV-1 wraps to 0 and
//     slot increments 0..7, 7 wraps to 0. en=0 clears cnt and slot synchronously.
//   States (from cnt): BLANK when cnt < BLANK_CYC, DRIVE otherwise.
//   Outputs are registered: values in cycle n+1 reflect cnt/slot/active in cycle n.
//     BLANK or en=0: digit=0, seg_data=0.
//     DRIVE: digit=8'h80>>slot, seg_data={seg(active[slot].bcd), active[slot].dp}.
//   Segment map (abcdefg): 0=1111110 1=0110000 2=1101101 3=1111001 4=0110011
//     5=1011011 6=0011111 7=1110000 8=1111111 9=1110011, 10..31=0000000 (dp still driven).
//   Writes: wr_en stores {wr_bcd,wr_dp} into shadow[wr_addr] at the edge; never touches active.
//   Commit: commit=1 sets pending; repeated commits while pending are absorbed (one swap).
//     Swap edge = edge where en=1, slot==7, cnt==CLK_DIV-1, pending==1: active<=shadow (shadow
//     values before that edge, i.e. a same-cycle write is NOT included), pending<=0,
//     commit_ack=1 for the following cycle. commit in the swap cycle itself sets pending
//     again (takes effect next frame). commit while en=0 stays pending until scanning resumes.
//   frame_start: 1 in the output cycle following cnt==0 && slot==0 with en=1 (coincides with
//     commit_ack when a swap occurred).
//   Reset mid-frame: all state returns to reset values next edge; pending commit is dropped.
// TESTING  (CLK_DIV=8, BLANK_CYC=2)
//   After reset, en=1, no writes -> digit walks 80,40,..,01 each 8 cycles, seg_data=0 always,
//     digit=0 for first 2 output cycles of every slot.
//   Write 1,9,9,6.,0,4.,1,3. to addr 0..7, commit -> commit_ack+frame_start one cycle, then
//     slot0 seg_data=8'b0110_0000, slot3 seg_data=8'b0011_1111, slot7 seg_data=8'b1111_0011.
//   Write addr 2=5 with no commit -> display unchanged for 3 full frames; commit -> 5 appears
//     (seg 8'b1011_0110) only from the next frame start, never mid-frame.
//   Write + commit in the swap cycle -> that write shown one frame later; exactly one extra ack.
//   en=0 mid-slot -> outputs 0 next cycle, cnt/slot 0; en=1 -> scan restarts at slot 0, frame_start.
//   reset=1 mid-frame with pending commit -> outputs 0, no commit_ack afterwards, buffers blank.

Source files
------------

// File: rtl/seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_if
// Description : Host-side bus of the 8-digit 7-segment scan controller.
//               Carries the scan enable, the shadow-buffer write port, the
//               commit handshake and the digit/segment drive outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_if;

  // Scan control and shadow-buffer write port (host -> controller)
  logic       en;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [4:0] wr_bcd;
  logic       wr_dp;
  logic       commit;

  // Handshake and display drive (controller -> host / board)
  logic       commit_ack;
  logic       frame_start;
  logic [7:0] digit;
  logic [7:0] seg_data;

  // Host side: drives control and writes, observes status and drive lines
  modport master (
    output en,
    output wr_en,
    output wr_addr,
    output wr_bcd,
    output wr_dp,
    output commit,
    input  commit_ack,
    input  frame_start,
    input  digit,
    input  seg_data
  );

  // Controller side
  modport slave (
    input  en,
    input  wr_en,
    input  wr_addr,
    input  wr_bcd,
    input  wr_dp,
    input  commit,
    output commit_ack,
    output frame_start,
    output digit,
    output seg_data
  );

endinterface : seg_scan_if
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Multiplexed 8-digit 7-segment display controller with a
//               double-buffered frame. The host fills a shadow buffer; a
//               commit copies it into the displayed buffer only at a frame
//               boundary so a frame is never shown half-updated. Each digit
//               slot lasts CLK_DIV cycles and opens with BLANK_CYC cycles of
//               all-off drive to suppress ghosting between digits.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int unsigned CLK_DIV   = 500,  // clk cycles per digit slot (>= BLANK_CYC+1)
  parameter int unsigned BLANK_CYC = 16    // all-off cycles at the start of each slot
) (
  input  logic       clk,
  input  logic       reset,
  seg_scan_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int unsigned CNT_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;
  localparam logic [2:0]       C_SLOT_LAST = 3'd7;
  // Buffer entry is {bcd[4:0], dp}; reset value is a blank digit, dp off
  localparam logic [5:0]       C_ENTRY_RST = {5'h1F, 1'b0};

  // --------------------------------------------------------------------------
  // BCD to {a,b,c,d,e,f,g}; values above 9 render as a blank digit
  // --------------------------------------------------------------------------
  function automatic logic [6:0] seg_lut(input logic [4:0] bcd);
    logic [6:0] s;
    case (bcd)
      5'd0:    s = 7'b1111110;
      5'd1:    s = 7'b0110000;
      5'd2:    s = 7'b1101101;
      5'd3:    s = 7'b1111001;
      5'd4:    s = 7'b0110011;
      5'd5:    s = 7'b1011011;
      5'd6:    s = 7'b0011111;
      5'd7:    s = 7'b1110000;
      5'd8:    s = 7'b1111111;
      5'd9:    s = 7'b1110011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [5:0]       shadow_q [8];
  logic [5:0]       active_q [8];

  logic [CNT_W-1:0] cnt_q,  cnt_d;
  logic [2:0]       slot_q, slot_d;
  logic             pending_q, pending_d;
  logic             swapped_q;      // swap happened on the previous edge

  logic [7:0]       digit_q, digit_d;
  logic [7:0]       seg_q,   seg_d;
  logic             ack_q;
  logic             fs_q,    fs_d;

  // --------------------------------------------------------------------------
  // Decodes of the current scan position
  // --------------------------------------------------------------------------
  logic       w_blank;
  logic       w_last_cyc;
  logic       w_swap;
  logic [5:0] w_entry;

  // Anti-ghosting window: first BLANK_CYC cycles of every slot
  assign w_blank    = (32'(cnt_q) < BLANK_CYC);
  // Final cycle of the final slot: the edge closing it is the frame boundary
  assign w_last_cyc = (slot_q == C_SLOT_LAST) && (cnt_q == C_CNT_MAX);
  // The swap needs an outstanding commit and an actively scanning display
  assign w_swap     = bus.en && w_last_cyc && pending_q;
  assign w_entry    = active_q[slot_q];

  // Slot timer and digit index; both held at zero while scanning is disabled
  always_comb begin
    cnt_d  = cnt_q;
    slot_d = slot_q;
    if (!bus.en) begin
      cnt_d  = C_CNT_ZERO;
      slot_d = 3'd0;
    end else if (cnt_q == C_CNT_MAX) begin
      cnt_d  = C_CNT_ZERO;
      slot_d = slot_q + 3'd1;
    end else begin
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Commit bookkeeping: a commit arriving on the swap edge itself re-arms the
  // request for the following frame instead of being lost in the swap
  always_comb begin
    pending_d = pending_q | bus.commit;
    if (w_swap) begin
      pending_d = bus.commit;
    end
  end

  // Next drive values, computed from the position and buffer of this cycle
  always_comb begin
    digit_d = 8'h00;
    seg_d   = 8'h00;
    fs_d    = bus.en && (cnt_q == C_CNT_ZERO) && (slot_q == 3'd0);
    if (bus.en && !w_blank) begin
      digit_d = 8'h80 >> slot_q;
      seg_d   = {seg_lut(w_entry[5:1]), w_entry[0]};
    end
  end

  // Shadow buffer: host writes land here only, never directly on the display
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= C_ENTRY_RST;
      end
    end else if (bus.wr_en) begin
      shadow_q[bus.wr_addr] <= {bus.wr_bcd, bus.wr_dp};
    end
  end

  // Displayed buffer: whole-frame copy from shadow at the frame boundary.
  // A write in the same cycle is not part of the copy (old shadow is sampled).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        active_q[i] <= C_ENTRY_RST;
      end
    end else if (w_swap) begin
      for (int i = 0; i < 8; i++) begin
        active_q[i] <= shadow_q[i];
      end
    end
  end

  // Scan position and commit request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= C_CNT_ZERO;
      slot_q    <= 3'd0;
      pending_q <= 1'b0;
      swapped_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      pending_q <= pending_d;
      swapped_q <= w_swap;
    end
  end

  // Registered outputs. The ack is delayed one stage behind the swap so it
  // lands in the same cycle as the frame_start of the newly displayed frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q <= 8'h00;
      seg_q   <= 8'h00;
      fs_q    <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      digit_q <= digit_d;
      seg_q   <= seg_d;
      fs_q    <= fs_d;
      ack_q   <= swapped_q;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.seg_data    = seg_q;
  assign bus.frame_start = fs_q;
  assign bus.commit_ack  = ack_q;

endmodule : seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Directed, table-driven bench for seg_scan_ctrl with
//               CLK_DIV=8 and BLANK_CYC=2 (one frame = 64 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int NONE = -1;

  typedef logic [7:0] disp_t [8];

  typedef struct {
    logic [2:0] addr;
    logic [4:0] bcd;
    logic       dp;
    logic [7:0] seg;   // expected seg_data while this digit is driven
  } vec_t;

  logic clk;
  logic reset;

  seg_scan_if bif ();

  seg_scan_ctrl #(
    .CLK_DIV   (8),
    .BLANK_CYC (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cur_p    = 0;

  vec_t  tbl1 [8];
  vec_t  tbl2 [8];
  disp_t d;
  disp_t zero_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s p=%0d t=%0t got=%0h expected=%0h", nm, cur_p, $time, act, exp);
    end
  endtask

  // Advance one cycle; sampling happens 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [4:0] b, input logic dp);
    bif.wr_en   = 1'b1;
    bif.wr_addr = a;
    bif.wr_bcd  = b;
    bif.wr_dp   = dp;
    tick();
    bif.wr_en   = 1'b0;
  endtask

  task automatic do_commit();
    bif.commit = 1'b1;
    tick();
    bif.commit = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_digit"}, 32'(bif.digit), 32'h0);
    chk({nm, "_seg"},   32'(bif.seg_data), 32'h0);
    chk({nm, "_fs"},    32'(bif.frame_start), 32'h0);
    chk({nm, "_ack"},   32'(bif.commit_ack), 32'h0);
  endtask

  task automatic wait_fs();
    int n = 0;
    while (bif.frame_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("wait_frame_start", 32'(bif.frame_start), 32'h1);
  endtask

  task automatic wait_ack();
    int n = 0;
    while (bif.commit_ack !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("wait_commit_ack", 32'(bif.commit_ack), 32'h1);
    chk("ack_with_frame_start", 32'(bif.frame_start), 32'h1);
  endtask

  // Check one frame, starting in the frame_start cycle (output position 0).
  // Optional actions are driven in the cycle at the given position and are
  // sampled by the edge that closes it. Normally ends in the next frame's
  // first cycle; with stop_at it returns in that cycle without advancing.
  task automatic check_frame(input disp_t exp, input logic exp_ack,
                             input int wr_at, input logic [2:0] wa,
                             input logic [4:0] wb, input logic wd,
                             input int cm_at, input int cm2_at, input int stop_at);
    for (int p = 0; p < 64; p++) begin
      logic [7:0] ed;
      logic [7:0] es;
      cur_p = p;
      if ((p % 8) < 2) begin
        ed = 8'h00;
        es = 8'h00;
      end else begin
        ed = 8'h80 >> (p / 8);
        es = exp[p / 8];
      end
      chk("digit", 32'(bif.digit), 32'(ed));
      chk("seg_data", 32'(bif.seg_data), 32'(es));
      chk("frame_start", 32'(bif.frame_start), (p == 0) ? 32'h1 : 32'h0);
      chk("commit_ack", 32'(bif.commit_ack), (p == 0) ? 32'(exp_ack) : 32'h0);
      if (p == stop_at) return;
      if (p == wr_at) begin
        bif.wr_en   = 1'b1;
        bif.wr_addr = wa;
        bif.wr_bcd  = wb;
        bif.wr_dp   = wd;
      end
      if (p == cm_at || p == cm2_at) bif.commit = 1'b1;
      tick();
      bif.wr_en  = 1'b0;
      bif.commit = 1'b0;
    end
  endtask

  task automatic plain_frame(input disp_t exp, input logic exp_ack);
    check_frame(exp, exp_ack, NONE, 3'd0, 5'd0, 1'b0, NONE, NONE, NONE);
  endtask

  initial begin
    // Digits "1 9 9 6. 0 4. 1 3." ; seg_data = {abcdefg, dp}
    tbl1[0] = '{3'd0, 5'd1, 1'b0, 8'h60};
    tbl1[1] = '{3'd1, 5'd9, 1'b0, 8'hE6};
    tbl1[2] = '{3'd2, 5'd9, 1'b0, 8'hE6};
    tbl1[3] = '{3'd3, 5'd6, 1'b1, 8'h3F};
    tbl1[4] = '{3'd4, 5'd0, 1'b0, 8'hFC};
    tbl1[5] = '{3'd5, 5'd4, 1'b1, 8'h67};
    tbl1[6] = '{3'd6, 5'd1, 1'b0, 8'h60};
    tbl1[7] = '{3'd7, 5'd3, 1'b1, 8'hF3};
    // Remaining glyphs plus blank codes (dp still shown on blanks)
    tbl2[0] = '{3'd0, 5'd2,  1'b0, 8'hDA};
    tbl2[1] = '{3'd1, 5'd5,  1'b0, 8'hB6};
    tbl2[2] = '{3'd2, 5'd7,  1'b1, 8'hE1};
    tbl2[3] = '{3'd3, 5'd8,  1'b0, 8'hFE};
    tbl2[4] = '{3'd4, 5'd10, 1'b1, 8'h01};
    tbl2[5] = '{3'd5, 5'd31, 1'b0, 8'h00};
    tbl2[6] = '{3'd6, 5'd15, 1'b1, 8'h01};
    tbl2[7] = '{3'd7, 5'd5,  1'b1, 8'hB7};
    for (int i = 0; i < 8; i++) zero_d[i] = 8'h00;

    reset       = 1'b1;
    bif.en      = 1'b0;
    bif.wr_en   = 1'b0;
    bif.wr_addr = 3'd0;
    bif.wr_bcd  = 5'd0;
    bif.wr_dp   = 1'b0;
    bif.commit  = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk_all_zero("reset");

    // Free scan of the blank reset frame
    reset  = 1'b0;
    bif.en = 1'b1;
    wait_fs();
    plain_frame(zero_d, 1'b0);

    // Load table 1, commit, expect it from the next frame boundary
    for (int i = 0; i < 8; i++) wr(tbl1[i].addr, tbl1[i].bcd, tbl1[i].dp);
    do_commit();
    wait_ack();
    for (int i = 0; i < 8; i++) d[i] = tbl1[i].seg;
    // Write digit 2 = 5 at the end of this frame, without committing
    check_frame(d, 1'b1, 63, 3'd2, 5'd5, 1'b0, NONE, NONE, NONE);
    plain_frame(d, 1'b0);
    plain_frame(d, 1'b0);
    // Commit mid-frame: the rest of this frame must still show the old value
    check_frame(d, 1'b0, NONE, 3'd0, 5'd0, 1'b0, 20, NONE, NONE);
    d[2] = 8'hB6;
    // Stage digit 0 = 8 in the shadow without committing
    check_frame(d, 1'b1, 40, 3'd0, 5'd8, 1'b0, NONE, NONE, NONE);

    // Commit early, then write digit 1 = 7 plus commit in the swap cycle
    check_frame(d, 1'b0, 62, 3'd1, 5'd7, 1'b0, 10, 62, NONE);
    d[0] = 8'hFE;
    plain_frame(d, 1'b1);
    d[1] = 8'hE0;
    plain_frame(d, 1'b1);
    plain_frame(d, 1'b0);

    // Disable mid-slot, commit while disabled, resume
    check_frame(d, 1'b0, 5, 3'd3, 5'd9, 1'b0, NONE, NONE, 29);
    bif.en = 1'b0;
    tick();
    chk_all_zero("en_off");
    bif.commit = 1'b1;
    tick();
    bif.commit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all_zero("en_off_hold");
    end
    bif.en = 1'b1;
    tick();
    plain_frame(d, 1'b0);
    d[3] = 8'hE6;
    plain_frame(d, 1'b1);

    // Reset mid-frame with a commit outstanding
    check_frame(d, 1'b0, 3, 3'd4, 5'd2, 1'b1, 10, NONE, 30);
    reset = 1'b1;
    tick();
    chk_all_zero("mid_reset");
    tick();
    chk_all_zero("mid_reset_hold");
    reset = 1'b0;
    tick();
    plain_frame(zero_d, 1'b0);
    plain_frame(zero_d, 1'b0);

    // Table 2 glyphs
    for (int i = 0; i < 8; i++) wr(tbl2[i].addr, tbl2[i].bcd, tbl2[i].dp);
    do_commit();
    wait_ack();
    for (int i = 0; i < 8; i++) d[i] = tbl2[i].seg;
    plain_frame(d, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_seg_scan_ctrl
`default_nettype wire
